// File: rtl/kdtree_wbs_pkg.sv
// Shared types and constants for the KD-tree accelerator Wishbone bridge:
// region bases, CSR offsets, SRAM widths and the bus FSM states.
package kdtree_wbs_pkg;

  localparam int unsigned MEM_DW  = 64;
  localparam int unsigned NODE_DW = 22;

  localparam logic [15:0] BaseRegs  = 16'h3000;
  localparam logic [15:0] BaseQuery = 16'h3001;
  localparam logic [15:0] BaseLeaf  = 16'h3002;
  localparam logic [15:0] BaseBest  = 16'h3003;
  localparam logic [15:0] BaseNode  = 16'h3004;

  localparam logic [15:0] OffMode  = 16'h0000;
  localparam logic [15:0] OffDebug = 16'h0004;
  localparam logic [15:0] OffDone  = 16'h0008;
  localparam logic [15:0] OffStart = 16'h000C;
  localparam logic [15:0] OffBusy  = 16'h0010;

  // Bit positions inside the packed per-window chip-select vector.
  localparam int unsigned CsbQuery = 0;
  localparam int unsigned CsbLeaf  = 1;
  localparam int unsigned CsbNode  = 2;
  localparam int unsigned CsbBest  = 3;

  typedef enum logic [2:0] {
    RgnRegs, RgnQuery, RgnLeaf, RgnBest, RgnNode, RgnNone
  } region_e;

  typedef enum logic [2:0] {
    CsrMode, CsrDebug, CsrDone, CsrStart, CsrBusy, CsrNone
  } csr_e;

  typedef enum logic [1:0] {
    StIdle, StAccess, StRdWait, StAck
  } state_e;

endpackage

// File: rtl/wbs_kdtree_bridge_if.sv
// Wishbone classic bus bundle between the Caravel port and the KD-tree bridge.
interface wbs_kdtree_bridge_if;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] adr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ack;

  modport master (output cyc, stb, we, sel, adr, wdata, input rdata, ack);
  modport slave  (input cyc, stb, we, sel, adr, wdata, output rdata, ack);
endinterface

// File: rtl/wbs_addr_decode.sv
// Combinational split of a Wishbone byte address into region, CSR, entry index
// and 32-bit half (adr[1]) for the KD-tree bridge.
module wbs_addr_decode
  import kdtree_wbs_pkg::*;
#(
  parameter int unsigned MEM_AW = 13
) (
  input  logic [31:0]       adr_i,
  output region_e           region_o,
  output csr_e              csr_o,
  output logic              upper_o,
  output logic [MEM_AW-1:0] index_o
);

  always_comb begin
    region_o = RgnNone;
    case (adr_i[31:16])
      BaseRegs:  region_o = RgnRegs;
      BaseQuery: region_o = RgnQuery;
      BaseLeaf:  region_o = RgnLeaf;
      BaseBest:  region_o = RgnBest;
      BaseNode:  region_o = RgnNode;
      default:   region_o = RgnNone;
    endcase
  end

  always_comb begin
    csr_o = CsrNone;
    case (adr_i[15:0])
      OffMode:  csr_o = CsrMode;
      OffDebug: csr_o = CsrDebug;
      OffDone:  csr_o = CsrDone;
      OffStart: csr_o = CsrStart;
      OffBusy:  csr_o = CsrBusy;
      default:  csr_o = CsrNone;
    endcase
  end

  assign upper_o = adr_i[1];
  assign index_o = adr_i[MEM_AW+1:2];

endmodule

// File: rtl/wbs_kdtree_bridge.sv
// Wishbone slave front end of the KD-tree ANN accelerator: CSRs plus query/leaf/best/node
// SRAM windows. Defining WBS_ERR_FLAG_EN adds a sticky error flag at DEBUG[31].
module wbs_kdtree_bridge
  import kdtree_wbs_pkg::*;
#(
  parameter int unsigned MEM_AW = 13,
  parameter int unsigned RD_LAT = 1
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  wbs_kdtree_bridge_if.slave   wbs,
  output logic [MEM_AW-1:0]    mem_addr,
  output logic [MEM_DW-1:0]    mem_wdata,
  output logic                 mem_web,
  output logic                 query_csb,
  output logic                 leaf_csb,
  output logic                 node_csb,
  output logic                 best_csb,
  input  logic [MEM_DW-1:0]    best_rdata,
  output logic                 mode_o,
  output logic                 debug_o,
  output logic                 fsm_start_o,
  input  logic                 fsm_done_i,
  input  logic                 fsm_busy_i
);

  localparam int unsigned CntW = 2;

  region_e           region;
  csr_e              csr;
  logic              upper;
  logic [MEM_AW-1:0] index;

  wbs_addr_decode #(.MEM_AW(MEM_AW)) u_decode (
    .adr_i    (wbs.adr),
    .region_o (region),
    .csr_o    (csr),
    .upper_o  (upper),
    .index_o  (index)
  );

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                abort_q, abort_d;
  logic                ack_q, ack_d;
  logic [31:0]         dat_q, dat_d;
  logic                mode_q, mode_d, debug_q, debug_d, start_q, start_d;
  logic [31:0]         lo_hold_q, lo_hold_d;
  logic [MEM_DW-1:0]   rd_hold_q, rd_hold_d;
  logic [MEM_AW-1:0]   addr_q, addr_d;
  logic [MEM_DW-1:0]   wdata_q, wdata_d;
  logic                web_q, web_d;
  logic [3:0]          csb_q, csb_d;
`ifdef WBS_ERR_FLAG_EN
  logic                err_q, err_d, lo_valid_q, lo_valid_d;
`endif

  logic req, is_qlf, lo_write, hi_write, node_write, best_lo_read;
  logic [31:0] rd_data;
  logic unused_sel;

  assign req          = wbs.cyc & wbs.stb;
  assign is_qlf       = (region == RgnQuery) | (region == RgnLeaf);
  assign lo_write     = is_qlf & wbs.we & ~upper;
  assign hi_write     = is_qlf & wbs.we & upper;
  assign node_write   = (region == RgnNode) & wbs.we;
  assign best_lo_read = (region == RgnBest) & ~wbs.we & ~upper;
  assign unused_sel   = ^wbs.sel;

  // Read data for every single-cycle access; writes and write-only/unmapped targets give 0.
  always_comb begin
    rd_data = '0;
    if (!wbs.we) begin
      case (region)
        RgnRegs: begin
          case (csr)
            CsrMode:  rd_data[0] = mode_q;
            CsrDebug: begin
              rd_data[0] = debug_q;
`ifdef WBS_ERR_FLAG_EN
              rd_data[31] = err_q;
`endif
            end
            CsrDone:  rd_data[0] = fsm_done_i;
            CsrBusy:  rd_data[0] = fsm_busy_i;
            default:  ;
          endcase
        end
        RgnBest: if (upper) rd_data = rd_hold_q[63:32];
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    abort_d   = abort_q;
    ack_d     = 1'b0;
    dat_d     = '0;
    mode_d    = mode_q;
    debug_d   = debug_q;
    start_d   = 1'b0;
    lo_hold_d = lo_hold_q;
    rd_hold_d = rd_hold_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    web_d     = 1'b1;
    csb_d     = '1;
`ifdef WBS_ERR_FLAG_EN
    err_d      = err_q;
    lo_valid_d = lo_valid_q;
`endif
    unique case (state_q)
      StIdle: begin
        // SRAM strobes are registered here so they are live for exactly the ACCESS cycle.
        if (req) begin
          state_d = StAccess;
          addr_d  = index;
          if (hi_write) begin
            wdata_d = {wbs.wdata, lo_hold_q};
            web_d   = 1'b0;
            if (region == RgnLeaf) csb_d[CsbLeaf] = 1'b0;
            else                   csb_d[CsbQuery] = 1'b0;
          end else if (node_write) begin
            wdata_d        = MEM_DW'(wbs.wdata[NODE_DW-1:0]);
            web_d          = 1'b0;
            csb_d[CsbNode] = 1'b0;
          end else if (best_lo_read) begin
            csb_d[CsbBest] = 1'b0;
          end
        end
      end
      StAccess: begin
        if (lo_write) lo_hold_d = wbs.wdata;
        if (wbs.we && region == RgnRegs) begin
          case (csr)
            CsrMode:  mode_d = wbs.wdata[0];
            CsrDebug: begin
              debug_d = wbs.wdata[0];
`ifdef WBS_ERR_FLAG_EN
              if (wbs.wdata[31]) err_d = 1'b0;
`endif
            end
            CsrStart: start_d = wbs.wdata[0];
            default:  ;
          endcase
        end
`ifdef WBS_ERR_FLAG_EN
        if (region == RgnNone) err_d = 1'b1;
        if (lo_write) lo_valid_d = 1'b1;
        if (hi_write) begin
          if (!lo_valid_q) err_d = 1'b1;
          lo_valid_d = 1'b0;
        end
`endif
        if (best_lo_read) begin
          state_d = StRdWait;
          cnt_d   = '0;
          abort_d = 1'b0;
        end else begin
          state_d = StAck;
          ack_d   = 1'b1;
          dat_d   = rd_data;
        end
      end
      StRdWait: begin
        // The read always completes into rd_hold; a dropped request only suppresses the ack.
        if (cnt_q == CntW'(RD_LAT - 1)) begin
          rd_hold_d = best_rdata;
          if (abort_q || !req) begin
            state_d = StIdle;
          end else begin
            state_d = StAck;
            ack_d   = 1'b1;
            dat_d   = best_rdata[31:0];
          end
        end else begin
          cnt_d   = cnt_q + 1'b1;
          abort_d = abort_q | ~req;
        end
      end
      StAck:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      abort_q   <= 1'b0;
      ack_q     <= 1'b0;
      dat_q     <= '0;
      mode_q    <= 1'b0;
      debug_q   <= 1'b0;
      start_q   <= 1'b0;
      lo_hold_q <= '0;
      rd_hold_q <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      web_q     <= 1'b1;
      csb_q     <= '1;
`ifdef WBS_ERR_FLAG_EN
      err_q      <= 1'b0;
      lo_valid_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      abort_q   <= abort_d;
      ack_q     <= ack_d;
      dat_q     <= dat_d;
      mode_q    <= mode_d;
      debug_q   <= debug_d;
      start_q   <= start_d;
      lo_hold_q <= lo_hold_d;
      rd_hold_q <= rd_hold_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      web_q     <= web_d;
      csb_q     <= csb_d;
`ifdef WBS_ERR_FLAG_EN
      err_q      <= err_d;
      lo_valid_q <= lo_valid_d;
`endif
    end
  end

  assign wbs.ack     = ack_q;
  assign wbs.rdata   = dat_q;
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign mem_web     = web_q;
  assign query_csb   = csb_q[CsbQuery];
  assign leaf_csb    = csb_q[CsbLeaf];
  assign node_csb    = csb_q[CsbNode];
  assign best_csb    = csb_q[CsbBest];
  assign mode_o      = mode_q;
  assign debug_o     = debug_q;
  assign fsm_start_o = start_q;

endmodule
